riscv_dmem_mmio: RTL

- Data-bus responder for the single-cycle RISC-V core: serves loads and stores issued on the core's MemWrite / ALUResult / WriteData / ReadData interface.
- Contains a word-addressed data RAM plus a memory-mapped register block: LED output, free-running cycle counter and a compare timer with interrupt flag.
- Reads are combinational so the single-cycle core gets ReadData in the same cycle. Writes and all counters update on the rising edge of clk.

---
 rtl/riscv_dmem_mmio_if.sv | 11 +
 rtl/riscv_dmem_mmio.sv | 127 ++++++++++++
 2 files changed

// File: rtl/riscv_dmem_mmio_if.sv
// Data-bus interface between the single-cycle RISC-V core and its data memory/MMIO responder.
// No valid/ready pair: reads are always valid combinationally, MemWrite is a one-cycle store strobe.
interface riscv_dmem_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output ALUResult, output WriteData, input ReadData);
  modport slave  (input MemWrite, input ALUResult, input WriteData, output ReadData);
endinterface

// File: rtl/riscv_dmem_mmio.sv
// Data RAM plus memory-mapped LED, cycle counter and compare timer for the single-cycle core.
// Reads are combinational; every write and counter update happens on the rising clock edge.
module riscv_dmem_mmio #(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic                clk,
    input  logic                reset,
    riscv_dmem_mmio_if.slave    bus,
    output logic [15:0]         leds,
    output logic                timer_irq
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [5:0] OFF_LED   = 6'h00;
    localparam logic [5:0] OFF_CYCLE = 6'h01;
    localparam logic [5:0] OFF_CMP   = 6'h02;
    localparam logic [5:0] OFF_CTRL  = 6'h03;
    localparam logic [5:0] OFF_CNT   = 6'h04;

    logic [31:0] ram [RAM_WORDS];

    logic [31:0] led_q;
    logic [31:0] cycle_q;
    logic [31:0] cmp_q;
    logic [31:0] cnt_q;
    logic        en_q;
    logic        reload_q;
    logic        flag_q;

    logic          ram_sel;
    logic          mmio_sel;
    logic [AW-1:0] ram_idx;
    logic [5:0]    word_off;
    logic          wr_ram, wr_led, wr_cmp, wr_ctrl, wr_cnt;
    logic          match;
    logic [31:0]   cnt_d;
    logic          en_d, reload_d, flag_d;
    logic          unused_addr_bits;

    // Byte-lane bits never select anything: all accesses are whole words.
    assign unused_addr_bits = ^{bus.ALUResult[1:0], bus.ALUResult[7:6] & 2'b00};

    assign ram_sel  = (bus.ALUResult[31:AW+2] == '0);
    assign ram_idx  = bus.ALUResult[AW+1:2];
    assign mmio_sel = (bus.ALUResult[31:8] == MMIO_BASE[31:8]);
    assign word_off = bus.ALUResult[7:2];

    assign wr_ram  = bus.MemWrite && ram_sel;
    assign wr_led  = bus.MemWrite && mmio_sel && (word_off == OFF_LED);
    assign wr_cmp  = bus.MemWrite && mmio_sel && (word_off == OFF_CMP);
    assign wr_ctrl = bus.MemWrite && mmio_sel && (word_off == OFF_CTRL);
    assign wr_cnt  = bus.MemWrite && mmio_sel && (word_off == OFF_CNT);

    always_comb begin
        bus.ReadData = '0;
        if (ram_sel) begin
            bus.ReadData = ram[ram_idx];
        end else if (mmio_sel) begin
            case (word_off)
                OFF_LED:   bus.ReadData = led_q;
                OFF_CYCLE: bus.ReadData = cycle_q;
                OFF_CMP:   bus.ReadData = cmp_q;
                OFF_CTRL:  bus.ReadData = {29'b0, flag_q, reload_q, en_q};
                OFF_CNT:   bus.ReadData = cnt_q;
                default:   bus.ReadData = '0;
            endcase
        end
    end

    // Timer next state. The match uses pre-edge cnt/cmp; a core write to a
    // field wins over what the timer itself would do, except that a match
    // setting the flag wins over a write-1-to-clear in the same cycle.
    assign match = en_q && (cnt_q == cmp_q);

    always_comb begin
        cnt_d    = cnt_q;
        en_d     = en_q;
        reload_d = reload_q;
        flag_d   = flag_q;

        if (match) begin
            if (reload_q) cnt_d = '0;
            else          en_d  = 1'b0;
        end else if (en_q) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (wr_cnt) cnt_d = bus.WriteData;

        if (wr_ctrl) begin
            en_d     = bus.WriteData[0];
            reload_d = bus.WriteData[1];
            if (bus.WriteData[2]) flag_d = 1'b0;
        end
        if (match) flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= '0;
            cycle_q  <= '0;
            cmp_q    <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            cycle_q  <= cycle_q + 32'd1;
            if (wr_led) led_q <= bus.WriteData;
            if (wr_cmp) cmp_q <= bus.WriteData;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            reload_q <= reload_d;
            flag_q   <= flag_d;
        end
    end

    // RAM has no reset; its contents survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_ram) ram[ram_idx] <= bus.WriteData;
    end

    assign leds      = led_q[15:0];
    assign timer_irq = flag_q;

endmodule
